// File: rtl/i2c_target.sv
// i2c_target: I2C target that ACKs its 7-bit address, receives written bytes and returns tx_data on reads.
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h2A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);
    localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_ADDR_ACK = 3'd2, S_WR = 3'd3,
                           S_WR_ACK = 3'd4, S_RD = 3'd5, S_RD_ACK = 3'd6, S_SKIP = 3'd7;
    logic [2:0] state, cnt, scl_q, sda_q;
    logic [6:0] shreg;
    logic [7:0] tx_sh;
    logic       rw, phase, sda, scl_rise, scl_fall, start_c, stop_c;
    // [0],[1] form the synchronizer, [2] is the history flop used for edge detection
    assign sda      = sda_q[1];
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start_c  = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    assign stop_c   = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt <= 3'd0;
            scl_q <= 3'b111;
            sda_q <= 3'b111;
            shreg <= 7'd0;
            tx_sh <= 8'd0;
            rw <= 1'b0;
            phase <= 1'b0;
            sda_oe <= 1'b0;
            rx_data <= 8'd0;
            rx_valid <= 1'b0;
            tx_req <= 1'b0;
            busy <= 1'b0;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
            rx_valid <= 1'b0;
            tx_req <= 1'b0;
            if (tx_req) tx_sh <= tx_data;
            if (stop_c) begin
                state <= S_IDLE;
                sda_oe <= 1'b0;
                busy <= 1'b0;
            end else if (start_c) begin
                state <= S_ADDR;
                cnt <= 3'd0;
                sda_oe <= 1'b0;
                phase <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    S_ADDR: begin
                        shreg <= {shreg[5:0], sda};
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state <= (shreg == ADDR) ? S_ADDR_ACK : S_SKIP;
                            busy <= (shreg == ADDR);
                            rw <= sda;
                            tx_req <= (shreg == ADDR) & sda;
                            phase <= 1'b0;
                        end
                    end
                    S_WR: begin
                        shreg <= {shreg[5:0], sda};
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            rx_data <= {shreg, sda};
                            rx_valid <= 1'b1;
                            state <= S_WR_ACK;
                            phase <= 1'b0;
                        end
                    end
                    S_RD: begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state <= S_RD_ACK;
                            phase <= 1'b0;
                        end
                    end
                    S_RD_ACK: begin
                        state <= sda ? S_SKIP : S_RD_ACK;
                        tx_req <= ~sda;
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    // first fall opens our ACK slot, second fall closes it
                    S_ADDR_ACK, S_WR_ACK: begin
                        phase <= ~phase;
                        if (!phase) sda_oe <= 1'b1;
                        else begin
                            state <= (state == S_ADDR_ACK && rw) ? S_RD : S_WR;
                            sda_oe <= (state == S_ADDR_ACK && rw) ? ~tx_sh[7] : 1'b0;
                        end
                    end
                    S_RD: begin
                        sda_oe <= ~tx_sh[6];
                        tx_sh <= {tx_sh[6:0], 1'b0};
                    end
                    S_RD_ACK: begin
                        phase <= ~phase;
                        if (!phase) sda_oe <= 1'b0;
                        else begin
                            state <= S_RD;
                            sda_oe <= ~tx_sh[7];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
